// File: rtl/rr_arbiter16_5bit_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
package rr_arbiter16_5bit_pkg;

  localparam int unsigned NREQ = 16;
  localparam int unsigned SELW = 4;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  // Low bit of requester idx's payload inside the packed req_data bus.
  function automatic int unsigned slice_lo(logic [SELW-1:0] idx, int unsigned dw);
    return dw * 32'(idx);
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin pick: first set bit of req starting at ptr, wrapping modulo 16.
module rr_pick16
  import rr_arbiter16_5bit_pkg::*;
(
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic        hit,
  output logic [3:0]  idx
);

  logic [31:0] shifted;
  logic [15:0] rot;
  logic [3:0]  off;

  // Rotate so that requester ptr lands on bit 0, then lowest set bit wins.
  assign shifted = {req, req} >> ptr;
  assign rot     = shifted[15:0];

  always_comb begin
    hit = |rot;
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
  end

  assign idx = ptr + off;

endmodule

// File: rtl/rr_arbiter16_5bit.sv
// 16-requester round-robin arbiter with registered valid/ready output.
// Optional ARB_LOCK_EN adds req_lock for bounded back-to-back bursts.
module rr_arbiter16_5bit
  import rr_arbiter16_5bit_pkg::*;
#(
  parameter int unsigned DW       = 5,
  parameter int unsigned PTR_RST  = 0,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    req,
  input  logic [16*DW-1:0] req_data,
  input  logic           out_ready,
`ifdef ARB_LOCK_EN
  input  logic [15:0]    req_lock,
`endif
  output logic [15:0]    grant,
  output logic [3:0]     sel,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  output logic [15:0]    done
);

  state_e          state_q, state_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [15:0]     grant_q, grant_d;
  logic [3:0]      sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [15:0]     done_q, done_d;

  logic [DW-1:0]   payload [NREQ];
  logic [3:0]      pick_ptr;
  logic            hit;
  logic [3:0]      win;
  logic            hs;
  logic            lock_hold;

  for (genvar g = 0; g < NREQ; g++) begin : g_payload
    assign payload[g] = req_data[slice_lo(SELW'(g), DW) +: DW];
  end

  assign hs = (state_q == StGrant) & out_ready;

  // After a handshake the just-served requester drops to lowest priority.
  assign pick_ptr = (state_q == StGrant) ? sel_q + 4'd1 : ptr_q;

  rr_pick16 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .hit (hit),
    .idx (win)
  );

`ifdef ARB_LOCK_EN
  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign lock_hold = req[sel_q] & req_lock[sel_q] & ((32'(cnt_q) + 1) < LOCK_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (hs) cnt_d = lock_hold ? cnt_q + CntW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_lock_max;
  assign unused_lock_max = |LOCK_MAX;
  assign lock_hold       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StGrant;
          grant_d = 16'd1 << win;
          sel_d   = win;
          valid_d = 1'b1;
          data_d  = payload[win];
        end
      end
      StGrant: begin
        if (hs) begin
          done_d = 16'd1 << sel_q;
          if (lock_hold) begin
            data_d = payload[sel_q];
          end else begin
            ptr_d = sel_q + 4'd1;
            if (hit) begin
              grant_d = 16'd1 << win;
              sel_d   = win;
              data_d  = payload[win];
            end else begin
              state_d = StIdle;
              grant_d = '0;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 4'(PTR_RST);
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rr_arbiter16_5bit.sv
// Self-checking bench for rr_arbiter16_5bit: vector table, corner sequences, random vs model.
module tb_rr_arbiter16_5bit;

  localparam int unsigned DW       = 5;
  localparam int unsigned LOCK_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       req;
  logic [16*DW-1:0]  req_data;
  logic              out_ready;
`ifdef ARB_LOCK_EN
  logic [15:0]       req_lock;
`endif
  logic [15:0]       grant;
  logic [3:0]        sel;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [15:0]       done;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic          m_valid;
  int            m_owner;
  logic [DW-1:0] m_data;
  logic [15:0]   m_done;
  int            m_ptr;
  int            m_burst;

  always #5 clk = ~clk;

  rr_arbiter16_5bit #(
    .DW       (DW),
    .PTR_RST  (0),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .out_ready (out_ready),
`ifdef ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    int j;
    for (int k = 0; k < 16; k++) begin
      j = (p + k) % 16;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] pay(input int i);
    logic [16*DW-1:0] s;
    s = req_data >> (DW * i);
    return s[DW-1:0];
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[DW*i +: DW] = v;
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_owner = 0;
    m_data  = '0;
    m_done  = '0;
    m_ptr   = 0;
    m_burst = 0;
  endfunction

  function automatic void model_load(input int w);
    m_valid = 1'b1;
    m_owner = w;
    m_data  = pay(w);
  endfunction

  function automatic void model_step();
    logic [15:0] nd;
    logic        stay;
    int          w;
    nd   = '0;
    stay = 1'b0;
    if (!m_valid) begin
      w = pick(req, m_ptr);
      if (w >= 0) model_load(w);
    end else if (out_ready) begin
      nd[m_owner] = 1'b1;
`ifdef ARB_LOCK_EN
      stay = req[m_owner] && req_lock[m_owner] && (m_burst + 1 < int'(LOCK_MAX));
`endif
      if (stay) begin
        m_burst++;
        m_data = pay(m_owner);
      end else begin
        m_burst = 0;
        m_ptr   = (m_owner + 1) % 16;
        w       = pick(req, m_ptr);
        if (w >= 0) model_load(w);
        else m_valid = 1'b0;
      end
    end
    m_done = nd;
  endfunction

  task automatic model_check();
    chk("grant", grant, m_valid ? (32'd1 << m_owner) : 32'd0);
    chk("out_valid", out_valid, m_valid);
    chk("done", done, m_done);
    chk("grant_onehot0", $onehot0(grant), 1);
    if (m_valid) begin
      chk("sel", sel, m_owner);
      chk("out_data", out_data, m_data);
    end
  endtask

  // One clock: model advances on the edge, DUT is sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic [15:0] g;
    logic        v;
    logic [15:0] d;
  } vec_t;

  vec_t tbl[6];
  int   lock_exp[6];

  initial begin
    tbl[0] = '{16'h0011, 1'b1, 16'h0001, 1'b1, 16'h0000};
    tbl[1] = '{16'h0011, 1'b1, 16'h0010, 1'b1, 16'h0001};
    tbl[2] = '{16'h0011, 1'b1, 16'h0001, 1'b1, 16'h0010};
    tbl[3] = '{16'h0011, 1'b1, 16'h0010, 1'b1, 16'h0001};
    tbl[4] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0010};
    tbl[5] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    lock_exp = '{1, 1, 1, 1, 2, 1};

    rst_n     = 1'b0;
    req       = 16'hFFFF;
    req_data  = '0;
    out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    req_lock  = '0;
`endif
    model_reset();

    // Reset with all requests pending
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", sel, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_grant", grant, 16'h0001);
    chk("rel_sel", sel, 0);
    req       = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // Rotation table from a fresh pointer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req       = tbl[i].req;
      out_ready = tbl[i].rdy;
      tick();
      chk("tbl_grant", grant, tbl[i].g);
      chk("tbl_valid", out_valid, tbl[i].v);
      chk("tbl_done", done, tbl[i].d);
    end

    // Backpressure: payload and owner held, late req_data change ignored
    set_data(7, 5'd19);
    req       = 16'h0080;
    out_ready = 1'b0;
    tick();
    chk("bp_sel", sel, 7);
    chk("bp_data", out_data, 19);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) set_data(7, 5'd3);
      tick();
      chk("bp_hold_sel", sel, 7);
      chk("bp_hold_data", out_data, 19);
      chk("bp_hold_done", done, 0);
    end
    req       = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_done", done, 16'h0080);
    tick();
    chk("bp_done_once", done, 0);

    // Wrap from 15 to 0
    req       = 16'h4000;
    out_ready = 1'b0;
    tick();
    chk("wrap_g14", grant, 16'h4000);
    req       = 16'h8001;
    out_ready = 1'b1;
    tick();
    chk("wrap_g15", grant, 16'h8000);
    tick();
    chk("wrap_g0", grant, 16'h0001);
    req = '0;
    tick();
    tick();

    // Withdrawal: dropping req does not cancel the grant
    set_data(2, 5'd9);
    req       = 16'h0004;
    out_ready = 1'b0;
    tick();
    req = '0;
    tick();
    chk("wd_grant", grant, 16'h0004);
    chk("wd_data", out_data, 9);
    out_ready = 1'b1;
    tick();
    chk("wd_done", done, 16'h0004);
    chk("wd_idle", out_valid, 0);
    tick();

    // Reset mid-transfer drops it without a done pulse
    req       = 16'h0008;
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_reset();
    #1;
    chk("mrst_grant", grant, 0);
    chk("mrst_valid", out_valid, 0);
    tick();
    chk("mrst_done", done, 0);
    rst_n = 1'b1;
    req   = '0;
    tick();

`ifdef ARB_LOCK_EN
    do_reset();
    req       = 16'h0006;
    req_lock  = 16'h0002;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lock_sel", sel, lock_exp[i]);
    end
    req      = '0;
    req_lock = '0;
    tick();
    tick();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = '0;
      else req = 16'($urandom) & 16'($urandom);
      req_data  = 80'({$urandom(), $urandom(), $urandom()});
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef ARB_LOCK_EN
      req_lock  = 16'($urandom);
`endif
      if ($urandom_range(0, 149) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
